// File: rtl/alu_sequencer.sv
// alu_sequencer: program memory, PC and FETCH/EXEC decoder feeding reg_file_alu.
// Optional STEP_MODE_EN: adds a step input and a WAIT state that gates every FETCH.
module alu_sequencer #(
  parameter int DEPTH   = 16,
  parameter int INSTR_W = 20,
  localparam int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
`ifdef STEP_MODE_EN
  input  logic               step,
`endif
  input  logic               prog_we,
  input  logic [PW-1:0]      prog_addr,
  input  logic [INSTR_W-1:0] prog_data,
  input  logic [7:0]         alu_result,
  output logic [3:0]         RA1,
  output logic [3:0]         RA2,
  output logic [3:0]         WA,
  output logic               RegWrite,
  output logic               ALUSrc,
  output logic [1:0]         ALUControl,
  output logic [7:0]         imm,
  output logic               busy,
  output logic               done,
  output logic [PW-1:0]      pc
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EXEC, S_WAIT} state_e;

`ifdef STEP_MODE_EN
  localparam state_e S_RUN = S_WAIT;
`else
  localparam state_e S_RUN = S_FETCH;
`endif

  localparam logic [3:0] OP_BZ   = 4'h9;
  localparam logic [3:0] OP_JMP  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  logic [INSTR_W-1:0] mem [DEPTH];

  state_e             state_q, state_d;
  logic [PW-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               zero_q, zero_d;
  logic               done_q, done_d;

  logic [3:0]    op;
  logic          is_alu, is_imm;
  logic [PW-1:0] target;

  assign op     = ir_q[19:16];
  assign is_alu = (op >= 4'h1) && (op <= 4'h8);
  assign is_imm = (op >= 4'h5) && (op <= 4'h8);
  assign target = ir_q[PW-1:0];

  assign RA1  = ir_q[11:8];
  assign RA2  = ir_q[3:0];
  assign WA   = ir_q[15:12];
  assign imm  = ir_q[7:0];
  assign busy = (state_q != S_IDLE);
  assign done = done_q;
  assign pc   = pc_q;

  always_ff @(posedge clk) begin
    if (prog_we && (state_q == S_IDLE)) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    zero_d     = zero_q;
    done_d     = 1'b0;
    RegWrite   = 1'b0;
    ALUSrc     = 1'b0;
    ALUControl = '0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          pc_d    = '0;
          zero_d  = 1'b0;
        end
      end
      S_FETCH: begin
        ir_d    = mem[pc_q];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // R-type (op-1) and I-type (op-5) select the same low two bits.
        RegWrite   = is_alu;
        ALUSrc     = is_imm;
        ALUControl = is_alu ? 2'(op - 4'd1) : 2'b00;
        if (is_alu) zero_d = (alu_result == 8'h00);
        if (op == OP_HALT) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_RUN;
          if ((op == OP_JMP) || ((op == OP_BZ) && zero_q)) pc_d = target;
          else                                              pc_d = pc_q + PW'(1);
        end
      end
`ifdef STEP_MODE_EN
      S_WAIT: begin
        if (step) state_d = S_FETCH;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule
